lsu_stage: RTL



---
 rtl/lsu_stage_if.sv | 18 +
 rtl/lsu_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage_if.sv
// Data-memory request/grant/rvalid bus between the load/store stage (master)
// and the data memory (slave).
interface lsu_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage after the execute ALU: runs the dmem handshake, builds byte
// lanes, aligns/extends loads and registers the write-back result.
// Optional macro LSU_MISALIGN_CHECK_EN adds misalign_o and skips misaligned accesses.
module lsu_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               mem_re_i,
  input  logic               mem_we_i,
  input  logic [1:0]         mem_size_i,
  input  logic               mem_unsigned_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0]  reg_wdata_i,
  output logic               stall_o,
  lsu_stage_if.master        dmem,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0]  wb_wdata_o
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic               misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  addr_p1;
  logic [1:0]         size_p1;
  logic               uns_p1;
  logic               we_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [RADDR_W-1:0] waddr_p1;

  logic               mem_op, mis, accept;
  logic               stall_c;
  logic               res_vld, res_we, res_mis;
  logic [RADDR_W-1:0] res_waddr;
  logic [DATA_W-1:0]  res_data;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_rep(input logic [1:0] size, input logic [DATA_W-1:0] d);
    case (size)
      2'b00:   store_rep = {4{d[7:0]}};
      2'b01:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [1:0] size, input logic [1:0] lo,
                                                 input logic uns, input logic [DATA_W-1:0] rd);
    logic        [7:0]        b;
    logic        [15:0]       h;
    logic signed [7:0]        sb;
    logic signed [15:0]       sh;
    logic signed [DATA_W-1:0] sx;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00: begin
        sb = b;
        sx = sb;
        load_ext = uns ? {{(DATA_W-8){1'b0}}, b} : sx;
      end
      2'b01: begin
        sh = h;
        sx = sh;
        load_ext = uns ? {{(DATA_W-16){1'b0}}, h} : sx;
      end
      default: load_ext = rd;
    endcase
  endfunction

  assign mem_op = mem_re_i | mem_we_i;
`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = valid_i & mem_op &
               (((mem_size_i == 2'b01) & mem_addr_i[0]) | (mem_size_i[1] & (mem_addr_i[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif
  assign accept = valid_i & mem_op & ~mis;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    res_vld   = 1'b0;
    res_we    = 1'b0;
    res_mis   = 1'b0;
    res_waddr = wb_waddr_o;
    res_data  = wb_wdata_o;
    case (state_q)
      IDLE: begin
        if (valid_i && !mem_op) begin
          res_vld   = 1'b1;
          res_we    = (reg_waddr_i != '0);
          res_waddr = reg_waddr_i;
          res_data  = reg_wdata_i;
        end else if (mis) begin
          res_vld   = 1'b1;
          res_mis   = 1'b1;
          res_waddr = reg_waddr_i;
          res_data  = reg_wdata_i;
        end else if (accept) begin
          stall_c = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_c = ~(dmem.gnt & we_p1);
        if (dmem.gnt) begin
          if (we_p1) begin
            res_vld   = 1'b1;
            res_waddr = waddr_p1;
            state_d   = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = ~dmem.rvalid;
        if (dmem.rvalid) begin
          res_vld   = 1'b1;
          res_we    = (waddr_p1 != '0);
          res_waddr = waddr_p1;
          res_data  = load_ext(size_p1, addr_p1[1:0], uns_p1, dmem.rdata);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p0 -> p1: operand capture when a memory op is accepted
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && accept) begin
      addr_p1  <= mem_addr_i;
      size_p1  <= mem_size_i;
      uns_p1   <= mem_unsigned_i;
      we_p1    <= mem_we_i;
      wdata_p1 <= reg_wdata_i;
      waddr_p1 <= reg_waddr_i;
    end
  end

  // Bus outputs are forced to zero outside REQ, so reset clears them immediately.
  assign dmem.req   = (state_q == REQ);
  assign dmem.we    = dmem.req & we_p1;
  assign dmem.addr  = dmem.req ? {addr_p1[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.be    = dmem.req ? byte_en(size_p1, addr_p1[1:0]) : 4'b0000;
  assign dmem.wdata = dmem.we ? store_rep(size_p1, wdata_p1) : '0;
  assign stall_o    = rst_i & stall_c;

  // p1 -> write-back register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      wb_valid_o <= res_vld;
      wb_we_o    <= res_we;
      wb_waddr_o <= res_waddr;
      wb_wdata_o <= res_data;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_o <= res_mis;
`endif
    end
  end

`ifndef LSU_MISALIGN_CHECK_EN
  logic unused_mis;
  assign unused_mis = res_mis;
`endif

endmodule
